// File: rtl/mux_pipe_pkg.sv
// Shared constants and skid-buffer state encoding for mux_pipe.
package mux_pipe_pkg;

    localparam int unsigned MUX_PIPE_WIDTH  = 16;
    localparam int unsigned MUX_PIPE_NUM_IN = 16;

    typedef logic [1:0] skid_state_t;

    localparam skid_state_t ST_EMPTY = 2'd0;
    localparam skid_state_t ST_ONE   = 2'd1;
    localparam skid_state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/mux_pipe_skid.sv
// Two-entry in-order skid buffer; in_ready/out_valid come only from registers.
module mux_pipe_skid
    import mux_pipe_pkg::*;
#(
    parameter int unsigned PW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_payload
);

    skid_state_t   state_q;
    skid_state_t   state_d;
    logic [PW-1:0] tail_q;
    logic          accept;
    logic          pop;
    logic          load_head;
    logic          load_tail;
    logic          shift_head;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy transitions and which entry register loads this edge.
    always_comb begin
        state_d    = state_q;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_head = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    load_head = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_d   = ST_TWO;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d    = ST_ONE;
                    shift_head = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Handshake flops track the next state so they stay 0 through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d != ST_TWO);
            out_valid <= (state_d != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_payload <= '0;
            tail_q      <= '0;
        end else begin
            if (load_head) begin
                out_payload <= in_payload;
            end else if (shift_head) begin
                out_payload <= tail_q;
            end
            if (load_tail) begin
                tail_q <= in_payload;
            end
        end
    end

endmodule

// File: rtl/mux_pipe.sv
// Registered N:1 mux with out-of-range flag feeding a two-entry skid buffer.
// Optional out_par (XOR of out_data) when MUX_PIPE_PARITY_EN is defined.
module mux_pipe
    import mux_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = MUX_PIPE_WIDTH,
    parameter int unsigned NUM_IN = MUX_PIPE_NUM_IN,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_PIPE_PARITY_EN
    ,
    output logic                    out_par
`endif
);

`ifdef MUX_PIPE_PARITY_EN
    localparam int unsigned PW = WIDTH + 2;
`else
    localparam int unsigned PW = WIDTH + 1;
`endif

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    head;

    // Out-of-range selects fall through to all-zero data.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_err = (32'(in_sel) >= NUM_IN);

`ifdef MUX_PIPE_PARITY_EN
    assign in_payload = {^sel_data, sel_err, sel_data};
    assign out_par    = head[WIDTH+1];
`else
    assign in_payload = {sel_err, sel_data};
`endif

    assign out_data = head[WIDTH-1:0];
    assign out_err  = head[WIDTH];

    mux_pipe_skid #(
        .PW (PW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (head)
    );

endmodule

// File: tb/tb_mux_pipe.sv
// Self-checking bench for mux_pipe against a capacity-2 FIFO reference model.
// Parity checks are compiled in when MUX_PIPE_PARITY_EN is defined.
module tb_mux_pipe;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 10;
    localparam int unsigned SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [SW-1:0] in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_err;
    logic          out_valid;
    logic          out_ready;
`ifdef MUX_PIPE_PARITY_EN
    logic          out_par;
`endif

    typedef struct packed {
        logic         par;
        logic         err;
        logic [W-1:0] data;
    } res_t;

    logic [W-1:0] word [N];
    res_t         q[$];
    bit           up;
    int           n_checks;
    int           n_pass;
    int           rx_count;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            in_data[k*W +: W] = word[k];
        end
    end

    mux_pipe #(
        .WIDTH  (W),
        .NUM_IN (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_PIPE_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    function automatic res_t expect_of(input logic [SW-1:0] s);
        res_t r;
        if (int'(s) < int'(N)) begin
            r.data = word[s];
            r.err  = 1'b0;
        end else begin
            r.data = '0;
            r.err  = 1'b1;
        end
        r.par = ^r.data;
        return r;
    endfunction

    // One clock: compare outputs to the model, then advance model and DUT together.
    task automatic cycle();
        logic exp_rdy;
        logic acc;
        logic pp;
        res_t nxt;
        exp_rdy = up && (q.size() < 2);
        n_checks++;
        if (in_ready !== exp_rdy) $display("FAIL ready got %b exp %b @%0t", in_ready, exp_rdy, $time);
        else n_pass++;
        n_checks++;
        if (out_valid !== (q.size() != 0)) $display("FAIL valid got %b exp %b @%0t", out_valid, q.size() != 0, $time);
        else n_pass++;
        if (q.size() != 0) begin
            n_checks++;
            if (out_data !== q[0].data) $display("FAIL data got %h exp %h @%0t", out_data, q[0].data, $time);
            else n_pass++;
            n_checks++;
            if (out_err !== q[0].err) $display("FAIL err got %b exp %b @%0t", out_err, q[0].err, $time);
            else n_pass++;
`ifdef MUX_PIPE_PARITY_EN
            n_checks++;
            if (out_par !== q[0].par) $display("FAIL par got %b exp %b @%0t", out_par, q[0].par, $time);
            else n_pass++;
`endif
        end
        acc = in_valid && exp_rdy;
        pp  = out_ready && (q.size() != 0);
        nxt = expect_of(in_sel);
        if (out_valid === 1'b1 && out_ready) rx_count++;
        @(posedge clk);
        #1;
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(nxt);
        up = rst_n;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sel    = '0;
        for (int k = 0; k < N; k++) word[k] = W'($urandom);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0)
            $display("FAIL reset_vals got rdy=%b vld=%b data=%h err=%b exp 0/0/0/0",
                     in_ready, out_valid, out_data, out_err);
        else n_pass++;
        rst_n = 1'b1;
        up    = 1'b0;
        q.delete();
        cycle();
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_release got %b exp 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        word[5]   = 16'hA5A5;
        in_sel    = SW'(5);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_err !== 1'b0)
            $display("FAIL basic_sel5 got vld=%b data=%h err=%b exp 1/a5a5/0", out_valid, out_data, out_err);
        else n_pass++;
        repeat (2) cycle();
    endtask

    task automatic test_out_of_range();
        in_sel    = SW'(12);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_data !== '0 || out_err !== 1'b1)
            $display("FAIL oor_sel12 got data=%h err=%b exp 0000/1", out_data, out_err);
        else n_pass++;
        repeat (2) cycle();
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
        res_t          e0;
        res_t          e1;
        s0 = SW'(1);
        s1 = SW'(7);
        s2 = SW'(9);
        e0 = expect_of(s0);
        e1 = expect_of(s1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = s0;
        cycle();
        in_sel = s1;
        cycle();
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_ready_low got %b exp 0", in_ready);
        else n_pass++;
        in_sel = s2;
        repeat (3) cycle();
        n_checks++;
        if (out_data !== e0.data) $display("FAIL bp_head_hold got %h exp %h", out_data, e0.data);
        else n_pass++;
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (out_data !== e1.data) $display("FAIL bp_second got %h exp %h", out_data, e1.data);
        else n_pass++;
        in_valid = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic test_back_to_back();
        int rx0;
        int low_ready;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        rx0       = rx_count;
        low_ready = 0;
        for (int i = 0; i < 100; i++) begin
            in_sel   = SW'(i % 16);
            in_valid = 1'b1;
            if (in_ready !== 1'b1) low_ready++;
            cycle();
        end
        in_valid = 1'b0;
        repeat (2) cycle();
        n_checks++;
        if (low_ready != 0) $display("FAIL b2b_ready got %0d low cycles exp 0", low_ready);
        else n_pass++;
        n_checks++;
        if (rx_count - rx0 != 100) $display("FAIL b2b_count got %0d exp 100", rx_count - rx0);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) word[$urandom_range(0, N-1)] = W'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = SW'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = SW'(2);
        cycle();
        in_sel = SW'(11);
        cycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0 || out_err !== 1'b0)
            $display("FAIL mid_reset got vld=%b rdy=%b data=%h err=%b exp 0/0/0/0",
                     out_valid, in_ready, out_data, out_err);
        else n_pass++;
        q.delete();
        up = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        out_ready = 1'b1;
        repeat (3) cycle();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL mid_reset_stale got %b exp 0", out_valid);
        else n_pass++;
    endtask

`ifdef MUX_PIPE_PARITY_EN
    task automatic test_parity();
        word[3]   = 16'h0007;
        word[4]   = 16'h0003;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = SW'(3);
        cycle();
        n_checks++;
        if (out_par !== 1'b1) $display("FAIL par_0007 got %b exp 1", out_par);
        else n_pass++;
        in_sel = SW'(4);
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_par !== 1'b0) $display("FAIL par_0003 got %b exp 0", out_par);
        else n_pass++;
        repeat (2) cycle();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rx_count = 0;
        up       = 1'b0;
        test_reset();
        test_basic();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef MUX_PIPE_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
